// File: rtl/mips_mem_responder_pkg.sv
// Shared types and helpers for the MIPS memory responder.
// Loader FSM encoding, byte-lane constants and address range check.
package mips_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_RUN  = 3'd4
    } ld_state_e;

    localparam int         BYTE_W    = 8;
    localparam int         WORD_W    = 32;
    localparam int         CNT_W     = 16;
    localparam logic [1:0] LANE_LAST = 2'd3;

    // True when every address bit above the word index is zero.
    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core-side bus and loader stream bundle for the memory responder.
// slave: the responder; master: core plus program source.
interface mips_mem_responder_if;
    import mips_mem_responder_pkg::*;

    logic [31:0]       inst_addr;
    logic [31:0]       inst;
    logic [31:0]       data_addr;
    logic [31:0]       wdata;
    logic              data_wr;
    logic [31:0]       rdata;
    logic              ld_start;
    logic              ld_valid;
    logic [BYTE_W-1:0] ld_byte;
    logic              ld_ready;
    logic              cpu_nrst;
    logic              ld_done;

    modport slave (
        input  inst_addr, data_addr, wdata, data_wr,
        input  ld_start, ld_valid, ld_byte,
        output inst, rdata, ld_ready, cpu_nrst, ld_done
    );

    modport master (
        output inst_addr, data_addr, wdata, data_wr,
        output ld_start, ld_valid, ld_byte,
        input  inst, rdata, ld_ready, cpu_nrst, ld_done
    );

endinterface

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: 16-bit big-endian word count header,
// then big-endian words written to imem; holds the core in reset.
module mips_prog_loader
    import mips_mem_responder_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [BYTE_W-1:0]  ld_byte,
    output logic               ld_ready,
    output logic               cpu_nrst,
    output logic               ld_done,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [WORD_W-1:0]  imem_wdata
);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic [23:0]      word_q, word_d;
    logic             ready_q, ready_d;
    logic             run_q, run_d;
    logic             accept;
    logic             word_full;

    // Byte handshake and the imem write of a completed word.
    always_comb begin
        accept     = ld_valid && ready_q;
        word_full  = accept && !ld_start && (state_q == ST_DATA)
                     && (bcnt_q == LANE_LAST);
        imem_we    = word_full && ((ptr_q >> IMEM_AW) == '0);
        imem_waddr = ptr_q[IMEM_AW-1:0];
        imem_wdata = {word_q, ld_byte};
    end

    // Next-state logic; ld_start wins over a byte in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        if (ld_start) begin
            state_d = ST_HDR0;
            bcnt_d  = '0;
            ptr_d   = '0;
            word_d  = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_HDR0: begin
                    cnt_d[15:8] = ld_byte;
                    state_d     = ST_HDR1;
                end
                ST_HDR1: begin
                    cnt_d[7:0] = ld_byte;
                    if ({cnt_q[15:8], ld_byte} == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DATA;
                        ptr_d   = '0;
                        bcnt_d  = '0;
                    end
                end
                ST_DATA: begin
                    if (bcnt_q == LANE_LAST) begin
                        bcnt_d = '0;
                        ptr_d  = ptr_q + 16'd1;
                        cnt_d  = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                        word_d = {word_q[15:0], ld_byte};
                    end
                end
                default: ;
            endcase
        end
        ready_d = (state_d == ST_HDR0) || (state_d == ST_HDR1)
                  || (state_d == ST_DATA);
        run_d   = (state_d == ST_RUN);
    end

    // FSM registers with registered ready/run outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            ptr_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            run_q   <= run_d;
        end
    end

    assign ld_ready = ready_q;
    assign cpu_nrst = run_q;
    assign ld_done  = run_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Instruction and data memories for the single-cycle MIPS core,
// with zero-latency reads and a program loader filling imem.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    mips_mem_responder_if.slave   bus
);

    logic [WORD_W-1:0]  imem [2**IMEM_AW];
    logic [WORD_W-1:0]  dmem [2**DMEM_AW];

    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [WORD_W-1:0]  imem_wdata;
    logic               ld_ready;
    logic               cpu_nrst;
    logic               ld_done;
    logic               dmem_we;
    logic [IMEM_AW-1:0] iidx;
    logic [DMEM_AW-1:0] didx;

    mips_prog_loader #(
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .clk        (clk),
        .nrst       (nrst),
        .ld_start   (bus.ld_start),
        .ld_valid   (bus.ld_valid),
        .ld_byte    (bus.ld_byte),
        .ld_ready   (ld_ready),
        .cpu_nrst   (cpu_nrst),
        .ld_done    (ld_done),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    assign bus.ld_ready = ld_ready;
    assign bus.cpu_nrst = cpu_nrst;
    assign bus.ld_done  = ld_done;

    // Read muxing: out-of-range or pre-RUN fetches return zero.
    always_comb begin
        iidx    = bus.inst_addr[IMEM_AW+1:2];
        didx    = bus.data_addr[DMEM_AW+1:2];
        dmem_we = bus.data_wr && ld_done
                  && in_range(bus.data_addr, DMEM_AW);
        bus.inst = '0;
        if (ld_done && in_range(bus.inst_addr, IMEM_AW)) begin
            bus.inst = imem[iidx];
        end
        bus.rdata = '0;
        if (in_range(bus.data_addr, DMEM_AW)) begin
            bus.rdata = dmem[didx];
        end
    end

    // Loader writes to imem; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Core stores to dmem, only while the core runs.
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[didx] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder: byte-stream model plus
// directed load, store and reset scenarios.
module tb_mips_mem_responder;
    import mips_mem_responder_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;

    always #5 clk = ~clk;

    mips_mem_responder_if bus ();

    mips_mem_responder #(
        .IMEM_AW (8),
        .DMEM_AW (8)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 loading, 2 running; queue of accepted bytes.
    int          m_mode = 0;
    logic [7:0]  m_q[$];
    logic [31:0] m_imem [256];
    bit          m_iv   [256];
    logic [31:0] m_dmem [256];
    bit          m_dv   [256];

    always @(posedge clk or negedge nrst) begin
        int n, k, cnt;
        if (!nrst) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            if (m_mode == 2 && bus.data_wr && bus.data_addr[31:10] == 0) begin
                m_dmem[bus.data_addr[9:2]] = bus.wdata;
                m_dv[bus.data_addr[9:2]]   = 1'b1;
            end
            if (bus.ld_start) begin
                m_mode = 1;
                m_q.delete();
            end else if (m_mode == 1 && bus.ld_valid) begin
                m_q.push_back(bus.ld_byte);
                n = m_q.size();
                if (n >= 2) begin
                    cnt = {m_q[0], m_q[1]};
                    if (n > 2 && (n - 2) % 4 == 0) begin
                        k = (n - 2) / 4 - 1;
                        if (k < 256) begin
                            m_imem[k] = {m_q[n-4], m_q[n-3], m_q[n-2], m_q[n-1]};
                            m_iv[k]   = 1'b1;
                        end
                    end
                    if (n == 2 + 4 * cnt) m_mode = 2;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ld_ready", 32'(bus.ld_ready), 32'(m_mode == 1));
        chk("cpu_nrst", 32'(bus.cpu_nrst), 32'(m_mode == 2));
        chk("ld_done", 32'(bus.ld_done), 32'(m_mode == 2));
        if (m_mode != 2 || bus.inst_addr[31:10] != 0)
            chk("inst_zero", bus.inst, 32'h0);
        else if (m_iv[bus.inst_addr[9:2]])
            chk("inst", bus.inst, m_imem[bus.inst_addr[9:2]]);
        if (bus.data_addr[31:10] != 0)
            chk("rdata_zero", bus.rdata, 32'h0);
        else if (m_dv[bus.data_addr[9:2]])
            chk("rdata", bus.rdata, m_dmem[bus.data_addr[9:2]]);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        if (bus.ld_ready) acc++;
        step();
    endtask

    task automatic start;
        bus.ld_start = 1'b1;
        if (bus.ld_ready && bus.ld_valid) acc++;
        step();
        bus.ld_start = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int k);
        return 32'h5A00_0000 ^ (32'(k) * 32'h0101_0101);
    endfunction

    initial begin
        logic [7:0] prog [10];
        logic [31:0] w;
        prog = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'hAC, 8'h08, 8'h00, 8'h10};
        bus.inst_addr = 32'h0;
        bus.data_addr = 32'h0;
        bus.wdata     = 32'h0;
        bus.data_wr   = 1'b0;
        bus.ld_start  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_byte   = 8'h0;
        #1 nrst = 1'b0;
        step();
        step();
        chk("rst_cpu_nrst", 32'(bus.cpu_nrst), 32'h0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'h0);
        chk("rst_ld_done", 32'(bus.ld_done), 32'h0);
        nrst = 1'b1;
        step();

        // Two-word program
        bus.inst_addr = 32'h4;
        bus.ld_valid  = 1'b1;
        acc = 0;
        start();
        for (int i = 0; i < 9; i++) send(prog[i]);
        chk("pre_run_cpu_nrst", 32'(bus.cpu_nrst), 32'h0);
        chk("pre_run_inst", bus.inst, 32'h0);
        send(prog[9]);
        chk("run_cpu_nrst", 32'(bus.cpu_nrst), 32'h1);
        send(8'hFF);
        chk("accepted_bytes", 32'(acc), 32'd10);
        chk("inst_4", bus.inst, 32'hAC08_0010);
        bus.inst_addr = 32'h0;
        #1 chk("inst_0", bus.inst, 32'h2008_0005);
        bus.ld_valid = 1'b0;

        // Store then load with old/new visibility
        bus.data_addr = 32'h10;
        bus.wdata     = 32'h1111_1111;
        bus.data_wr   = 1'b1;
        step();
        bus.wdata = 32'hDEAD_BEEF;
        #1 chk("rd_old", bus.rdata, 32'h1111_1111);
        step();
        bus.data_wr = 1'b0;
        #1 chk("rd_new", bus.rdata, 32'hDEAD_BEEF);
        bus.data_addr = 32'h13;
        #1 chk("rd_unaligned", bus.rdata, 32'hDEAD_BEEF);

        // Out-of-range accesses
        bus.data_addr = 32'h0;
        bus.wdata     = 32'h5555_5555;
        bus.data_wr   = 1'b1;
        step();
        bus.data_addr = 32'h400;
        bus.wdata     = 32'h1234_5678;
        step();
        bus.data_wr = 1'b0;
        #1 chk("rd_oor", bus.rdata, 32'h0);
        bus.data_addr = 32'h0;
        #1 chk("rd_oor_kept", bus.rdata, 32'h5555_5555);
        bus.inst_addr = 32'h400;
        #1 chk("inst_oor", bus.inst, 32'h0);
        bus.inst_addr = 32'h0;

        // Empty program, then ld_start from RUN
        start();
        send(8'h00);
        chk("hdr00_not_yet", 32'(bus.cpu_nrst), 32'h0);
        send(8'h00);
        chk("hdr00_run", 32'(bus.cpu_nrst), 32'h1);
        chk("hdr00_done", 32'(bus.ld_done), 32'h1);
        start();
        chk("restart_cpu_nrst", 32'(bus.cpu_nrst), 32'h0);
        chk("restart_ld_done", 32'(bus.ld_done), 32'h0);

        // Mid-load restart drops the concurrent byte
        send(8'h00);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        bus.ld_start = 1'b1;
        bus.ld_byte  = 8'hCC;
        step();
        bus.ld_start = 1'b0;
        chk("midload_hdr0", 32'(dut.u_loader.state_q), 32'(ST_HDR0));
        send(8'h00);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        chk("reload_done", 32'(bus.ld_done), 32'h1);
        #1 chk("reload_inst", bus.inst, 32'h1234_5678);

        // Asynchronous reset during DATA
        start();
        send(8'h00);
        send(8'h01);
        send(8'h11);
        bus.ld_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("arst_state", 32'(dut.u_loader.state_q), 32'(ST_IDLE));
        chk("arst_ld_ready", 32'(bus.ld_ready), 32'h0);
        chk("arst_cpu_nrst", 32'(bus.cpu_nrst), 32'h0);
        #3 nrst = 1'b1;
        step();
        start();
        send(8'h00);
        send(8'h00);
        #1 chk("imem_kept", bus.inst, 32'h1234_5678);

        // 257 words into a 256-word imem
        start();
        send(8'h01);
        send(8'h01);
        for (int k = 0; k < 257; k++) begin
            w = word_of(k);
            send(w[31:24]);
            send(w[23:16]);
            send(w[15:8]);
            if (k == 256) chk("big_pre_run", 32'(bus.cpu_nrst), 32'h0);
            send(w[7:0]);
        end
        bus.ld_valid = 1'b0;
        chk("big_done", 32'(bus.ld_done), 32'h1);
        bus.inst_addr = 32'h0;
        #1 chk("big_word0", bus.inst, 32'h5A00_0000);
        bus.inst_addr = 32'h3FC;
        #1 chk("big_word255", bus.inst, 32'hA5FF_FFFF);
        for (int i = 0; i < 256; i++) begin
            bus.inst_addr = 32'(i * 4);
            step();
        end
        bus.inst_addr = 32'h400;
        #1 chk("big_oor", bus.inst, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
